// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the shared 8-bit internal bus: one-hot grant,
// mux/demux select, hold-limit revocation and a forced turnaround cycle.
module bus_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    state_t     state_q;
    logic [3:0] grant_q;
    logic [1:0] sel_q;
    logic       busy_q;
    logic       timeout_q;
    logic [1:0] last_q;
    logic [7:0] cnt_q;

    logic [1:0] win_d;
    logic       found_d;
    logic [1:0] idx_d;

    // Search last+1 .. last+4 so the previous owner is considered last.
    always_comb begin
        win_d   = last_q;
        found_d = 1'b0;
        idx_d   = last_q;
        for (int k = 1; k <= 4; k++) begin
            idx_d = last_q + 2'(k);
            if (req[idx_d] && !found_d) begin
                win_d   = idx_d;
                found_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= 4'b0000;
            sel_q     <= 2'b00;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            last_q    <= 2'b11;
            cnt_q     <= 8'd0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        state_q <= OWN;
                        grant_q <= 4'b0001 << win_d;
                        sel_q   <= win_d;
                        last_q  <= win_d;
                        busy_q  <= 1'b1;
                        cnt_q   <= 8'd1;
                    end
                end
                OWN: begin
                    // A dropped request wins over the limit: no timeout pulse then.
                    if (!req[sel_q]) begin
                        state_q <= IDLE;
                        grant_q <= 4'b0000;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == MAX_HOLD_C) begin
                        state_q   <= IDLE;
                        grant_q   <= 4'b0000;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 4'b0000;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scoreboard bench for bus_arbiter: three instances with hold limits
// 8, 3 and 4 share req/rst_n; each scenario checks the relevant instance.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;

    logic [3:0] grant_a, grant_b, grant_c;
    logic [1:0] sel_a, sel_b, sel_c;
    logic       busy_a, busy_b, busy_c;
    logic       timeout_a, timeout_b, timeout_c;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        int         dut;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    bus_arbiter #(.MAX_HOLD(8)) u_a (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant(grant_a), .sel(sel_a), .busy(busy_a), .timeout(timeout_a)
    );
    bus_arbiter #(.MAX_HOLD(3)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant(grant_b), .sel(sel_b), .busy(busy_b), .timeout(timeout_b)
    );
    bus_arbiter #(.MAX_HOLD(4)) u_c (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant(grant_c), .sel(sel_c), .busy(busy_c), .timeout(timeout_c)
    );

    function automatic logic [7:0] obs(input int dut);
        case (dut)
            0:       return {grant_a, sel_a, busy_a, timeout_a};
            1:       return {grant_b, sel_b, busy_b, timeout_b};
            default: return {grant_c, sel_c, busy_c, timeout_c};
        endcase
    endfunction

    // Packed expectation: {grant, sel, busy, timeout}
    function automatic logic [7:0] pk(input logic [3:0] g, input logic [1:0] s,
                                      input logic b, input logic t);
        return {g, s, b, t};
    endfunction

    task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed {grant,sel,busy,timeout}=%b expected=%b", tag, o, e);
        end
    endtask

    // Drive req before an edge, queue the expected post-edge outputs, then
    // pop and compare one time unit after the edge; returns on the next negedge.
    task automatic step(input string tag, input int dut, input logic [3:0] r,
                        input logic [7:0] e);
        exp_t item;
        req = r;
        item.tag = tag;
        item.dut = dut;
        item.exp = e;
        sb.push_back(item);
        @(posedge clk);
        #1;
        item = sb.pop_front();
        chk(item.tag, obs(item.dut), item.exp);
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        req   = 4'b0000;
        #1;
        chk("rst_a", obs(0), 8'h00);
        chk("rst_b", obs(1), 8'h00);
        chk("rst_c", obs(2), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] g;
        logic [1:0] s;

        // Reset state and single request
        #3;
        chk("reset_a", obs(0), 8'h00);
        chk("reset_b", obs(1), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step("idle_e1", 0, 4'b0000, pk(4'b0000, 2'd0, 1'b0, 1'b0));
        step("idle_e2", 0, 4'b0000, pk(4'b0000, 2'd0, 1'b0, 1'b0));
        step("single_grant", 0, 4'b0100, pk(4'b0100, 2'd2, 1'b1, 1'b0));
        step("single_hold", 0, 4'b0100, pk(4'b0100, 2'd2, 1'b1, 1'b0));
        step("single_release", 0, 4'b0000, pk(4'b0000, 2'd2, 1'b0, 1'b0));
        step("single_idle", 0, 4'b0000, pk(4'b0000, 2'd2, 1'b0, 1'b0));

        // Round-robin fairness, MAX_HOLD=8, all requesting
        reset_pulse();
        for (int o = 0; o < 5; o++) begin
            s = 2'(o % 4);
            g = 4'b0001 << s;
            for (int c = 0; c < 8; c++)
                step($sformatf("rr_own%0d_c%0d", o, c), 0, 4'b1111, pk(g, s, 1'b1, 1'b0));
            if (o < 4)
                step($sformatf("rr_timeout%0d", o), 0, 4'b1111, pk(4'b0000, s, 1'b0, 1'b1));
        end

        // Sole requester timeout, MAX_HOLD=3, period 4
        reset_pulse();
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 3; c++)
                step($sformatf("sole_p%0d_c%0d", p, c), 1, 4'b0010, pk(4'b0010, 2'd1, 1'b1, 1'b0));
            step($sformatf("sole_to_p%0d", p), 1, 4'b0010, pk(4'b0000, 2'd1, 1'b0, 1'b1));
        end
        step("sole_regrant", 1, 4'b0010, pk(4'b0010, 2'd1, 1'b1, 1'b0));

        // Release coinciding with hold limit, MAX_HOLD=4
        reset_pulse();
        for (int c = 0; c < 4; c++)
            step($sformatf("simul_own_c%0d", c), 2, 4'b0110, pk(4'b0010, 2'd1, 1'b1, 1'b0));
        step("simul_release_no_to", 2, 4'b0100, pk(4'b0000, 2'd1, 1'b0, 1'b0));
        step("simul_next_grant", 2, 4'b0100, pk(4'b0100, 2'd2, 1'b1, 1'b0));

        // Late requester does not preempt, MAX_HOLD=4
        reset_pulse();
        step("late_grant0", 2, 4'b0001, pk(4'b0001, 2'd0, 1'b1, 1'b0));
        step("late_hold0", 2, 4'b0001, pk(4'b0001, 2'd0, 1'b1, 1'b0));
        step("late_req3_ignored", 2, 4'b1001, pk(4'b0001, 2'd0, 1'b1, 1'b0));
        step("late_release0", 2, 4'b1000, pk(4'b0000, 2'd0, 1'b0, 1'b0));
        step("late_grant3", 2, 4'b1000, pk(4'b1000, 2'd3, 1'b1, 1'b0));

        // Asynchronous reset mid-grant, then pointer restarts at 3
        reset_pulse();
        step("async_pre_grant", 0, 4'b0010, pk(4'b0010, 2'd1, 1'b1, 1'b0));
        rst_n = 1'b0;
        #1;
        chk("async_drop_a", obs(0), 8'h00);
        #1;
        rst_n = 1'b1;
        step("async_first_grant", 0, 4'b1010, pk(4'b0010, 2'd1, 1'b1, 1'b0));

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: observed %0d pending entries, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
